mprj_io_serial_loader: RTL and testbench
========================================

// Module: mprj_io_serial_loader
// PURPOSE
//  Serialises per-pad user-project I/O configuration words onto the two GPIO
//  configuration chains (mprj_io_loader_resetn/clock/data_1/data_2).
//  Sits inside the management SoC between the I/O config register file and
//  the mgmt_core loader pins. Chain 1 serves the low pads, chain 2 the high pads.
//  Both chains shift simultaneously under one generated serial clock.
// PARAMETERS
//  NUM_PADS_1   19  pads on chain 1 (pad indices 0..NUM_PADS_1-1)
//  NUM_PADS_2   19  pads on chain 2 (pad indices NUM_PADS_1..NUM_PADS_1+NUM_PADS_2-1)
//  CFG_BITS     13  config bits per pad
//  HALF_PERIOD   2  clk cycles per serial_clock phase (>=1)
// PORTS
//  clk            in   1   core clock
//  reset          in   1   async, active-high reset
//  start          in   1   1-cycle pulse: begin a full load
//  busy           out  1   high from the cycle after accepted start until done
//  done           out  1   1-cycle pulse when the load completes
//  cfg_rd_en      out  1   read strobe to the config register file
//  cfg_rd_addr    out  6   pad index to read
//  cfg_rd_data    in   CFG_BITS  word for cfg_rd_addr, valid exactly 1 cycle after cfg_rd_en
//  serial_resetn  out  1   chain reset, active-low
//  serial_clock   out  1   chain shift clock; chain samples on the rising edge
//  serial_data_1  out  1   chain 1 data
//  serial_data_2  out  1   chain 2 data
// BEHAVIOUR
//  - Reset values: busy=0, done=0, cfg_rd_en=0, cfg_rd_addr=0, serial_resetn=0,
//    serial_clock=0, serial_data_1/2=0. Every output is registered.
//  - IDLE: serial_resetn=1 from the first clk after reset release. start is accepted
//    only in IDLE; start while busy is ignored.
//  - CHAIN_RST: serial_resetn=0 for 2*HALF_PERIOD cycles, then 1 for the rest of the load.
//  - Word slots: W = max(NUM_PADS_1,NUM_PADS_2), slot k = 0..W-1.
//    Chain 1 slot k carries pad NUM_PADS_1-1-(k-(W-NUM_PADS_1)).
//    Chain 2 slot k carries pad NUM_PADS_1+NUM_PADS_2-1-(k-(W-NUM_PADS_2)).
//    A slot with k < W-NUM_PADS_n is a zero word and issues no read.
//  - FETCH1/FETCH2: read the chain 1 word, then the chain 2 word (1-cycle latency each).
//    Each word is captured into its own CFG_BITS shift register.
//    serial_clock stays low during fetches.
//  - SHIFT: per bit, MSB first:
//    - data_1/data_2 update at the start of the low phase;
//    - serial_clock low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles.
//    After CFG_BITS bits, go to the next slot's FETCH1, or to FINISH after slot W-1.
//  - FINISH: serial_clock=0, data=0. done pulses 1 cycle, busy falls in that same cycle,
//    then return to IDLE.
//  - serial_clock rising edges per load = W*CFG_BITS exactly.
//  - Reset mid-load: all state and outputs return to reset values immediately.
//    No done pulse. A new start is needed afterwards.
//  - Counters: bit counter $clog2(CFG_BITS) bits, slot counter $clog2(W+1) bits;
//    neither wraps within a load.
// STRUCTURE
//  - Shared package/include mprj_loader_defs: state encoding (IDLE, CHAIN_RST, FETCH1,
//    FETCH2, SHIFT, FINISH), CFG_BITS default, pad-count defaults.
//  - One sub-module, serial_bit_timer: HALF_PERIOD divider. Emits phase_lo_start and
//    phase_hi_start strides, and is enabled only in CHAIN_RST/SHIFT.
//  - Top level holds the FSM, slot/bit counters, two shift registers and address generation.
// TESTING
//  1 Reset: hold reset, then release -> serial_resetn=0 during reset, 1 next cycle;
//    all other outputs 0.
//  2 Full load, defaults, memory word = 13'h1000|pad
//    -> 247 rising edges on serial_clock.
//    -> chain 1 first word is pad 18 = 0x1012, MSB first; chain 2 first word is pad 37 = 0x1025.
//    -> done pulses once.
//  3 Unequal chains NUM_PADS_1=3, NUM_PADS_2=5
//    -> chain 1 emits 2 zero words (26 zero bits), then pads 2,1,0.
//    -> no reads issued for the zero slots; 65 clock edges.
//  4 start pulsed again mid-load -> ignored; edge count and data unchanged;
//    a single done pulse.
//  5 reset asserted at slot 5, bit 7
//    -> outputs at reset values that cycle; no done pulse.
//    -> a following start gives a complete, correct load.
//  6 HALF_PERIOD=1 and =4 -> serial_clock period 2 and 8 clk cycles.
//    -> data stable through every rising edge (checker: data changes only while clock low).

Source files
------------

// File: rtl/mprj_io_serial_loader_pkg.sv
// Shared definitions for the GPIO configuration-chain loader: FSM states,
// default geometry and a small sizing helper.
package mprj_loader_defs;

   localparam int unsigned NUM_PADS_1_DEF  = 19;
   localparam int unsigned NUM_PADS_2_DEF  = 19;
   localparam int unsigned CFG_BITS_DEF    = 13;
   localparam int unsigned HALF_PERIOD_DEF = 2;

   typedef enum logic [2:0] {
      IDLE,
      CHAIN_RST,
      FETCH1,
      FETCH2,
      SHIFT,
      FINISH
   } loader_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mprj_io_serial_loader_bit_timer.sv
// Half-period divider for the configuration serial clock. While enabled it walks
// a low phase then a high phase, HALF_PERIOD cycles each, flagging phase starts.
module serial_bit_timer #(
   parameter int unsigned HALF_PERIOD = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic phase_lo_start,
   output logic phase_hi_start,
   output logic bit_end
);

   localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!en) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase_lo_start = en && !phase_q && (cnt_q == '0);
   assign phase_hi_start = en &&  phase_q && (cnt_q == '0);
   assign bit_end        = en &&  phase_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mprj_io_serial_loader.sv
// Loads per-pad configuration words onto the two GPIO config chains, both chains
// shifting MSB first under one generated serial clock.
module mprj_io_serial_loader
   import mprj_loader_defs::*;
#(
   parameter int unsigned NUM_PADS_1  = NUM_PADS_1_DEF,
   parameter int unsigned NUM_PADS_2  = NUM_PADS_2_DEF,
   parameter int unsigned CFG_BITS    = CFG_BITS_DEF,
   parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                cfg_rd_en,
   output logic [5:0]          cfg_rd_addr,
   input  logic [CFG_BITS-1:0] cfg_rd_data,
   output logic                serial_resetn,
   output logic                serial_clock,
   output logic                serial_data_1,
   output logic                serial_data_2
);

   localparam int unsigned W  = max_u(NUM_PADS_1, NUM_PADS_2);
   localparam int unsigned BW = $clog2(CFG_BITS);
   localparam int unsigned SW = $clog2(W + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(W - 1);
   // Slots below ZERO_n on chain n carry a zero word and never touch the register file.
   localparam logic [SW-1:0] ZERO_1 = SW'(W - NUM_PADS_1);
   localparam logic [SW-1:0] ZERO_2 = SW'(W - NUM_PADS_2);
   localparam logic [5:0]    TOP_1  = 6'(W - 1);
   localparam logic [5:0]    TOP_2  = 6'(NUM_PADS_1 + W - 1);

   loader_state_e       state_q, state_d;
   logic [SW-1:0]       slot_q, slot_d, slot_inc;
   logic [BW-1:0]       bit_q, bit_d;
   logic [1:0]          fetch_q, fetch_d;
   logic                live1_q, live1_d, live2_q, live2_d;
   logic [CFG_BITS-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                rd_en_q, rd_en_d;
   logic [5:0]          rd_addr_q, rd_addr_d;
   logic                resetn_q, resetn_d, sclk_q, sclk_d;
   logic                d1_q, d1_d, d2_q, d2_d;
   logic                timer_en, phase_lo_start, phase_hi_start, bit_end;
   logic                fetch_live;

   assign timer_en   = (state_q == CHAIN_RST) || (state_q == SHIFT);
   assign slot_inc   = slot_q + 1'b1;
   assign fetch_live = (state_q == FETCH1) ? live1_q : live2_q;

   serial_bit_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
      .clk           (clk),
      .rst           (reset),
      .en            (timer_en),
      .phase_lo_start(phase_lo_start),
      .phase_hi_start(phase_hi_start),
      .bit_end       (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      bit_d     = bit_q;
      fetch_d   = fetch_q;
      live1_d   = live1_q;
      live2_d   = live2_q;
      sr1_d     = sr1_q;
      sr2_d     = sr2_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      resetn_d  = resetn_q;
      sclk_d    = sclk_q;
      d1_d      = d1_q;
      d2_d      = d2_q;
      unique case (state_q)
         IDLE: begin
            resetn_d = 1'b1;
            if (start) begin
               state_d  = CHAIN_RST;
               busy_d   = 1'b1;
               resetn_d = 1'b0;
               slot_d   = '0;
               bit_d    = '0;
               live1_d  = (ZERO_1 == '0);
               live2_d  = (ZERO_2 == '0);
            end
         end
         CHAIN_RST: begin
            if (bit_end) begin
               resetn_d = 1'b1;
               fetch_d  = '0;
               state_d  = FETCH1;
            end
         end
         FETCH1, FETCH2: begin
            // Issue, wait one cycle for the registered strobe, then capture the returned word.
            sclk_d  = 1'b0;
            fetch_d = fetch_q + 1'b1;
            if (fetch_q == 2'd0 && fetch_live) begin
               rd_en_d   = 1'b1;
               rd_addr_d = (state_q == FETCH1) ? (TOP_1 - 6'(slot_q)) : (TOP_2 - 6'(slot_q));
            end
            if (fetch_q == 2'd2) begin
               fetch_d = '0;
               if (state_q == FETCH1) begin
                  sr1_d   = live1_q ? cfg_rd_data : '0;
                  state_d = FETCH2;
               end else begin
                  sr2_d   = live2_q ? cfg_rd_data : '0;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (phase_lo_start) begin
               sclk_d = 1'b0;
               d1_d   = sr1_q[CFG_BITS-1];
               d2_d   = sr2_q[CFG_BITS-1];
               sr1_d  = {sr1_q[CFG_BITS-2:0], 1'b0};
               sr2_d  = {sr2_q[CFG_BITS-2:0], 1'b0};
            end
            if (phase_hi_start) sclk_d = 1'b1;
            if (bit_end) begin
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
                  if (slot_q == SLOT_LAST) begin
                     state_d = FINISH;
                  end else begin
                     slot_d  = slot_inc;
                     live1_d = live1_q || (slot_inc == ZERO_1);
                     live2_d = live2_q || (slot_inc == ZERO_2);
                     fetch_d = '0;
                     state_d = FETCH1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         FINISH: begin
            sclk_d  = 1'b0;
            d1_d    = 1'b0;
            d2_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         slot_q    <= '0;
         bit_q     <= '0;
         fetch_q   <= '0;
         live1_q   <= 1'b0;
         live2_q   <= 1'b0;
         sr1_q     <= '0;
         sr2_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         resetn_q  <= 1'b0;
         sclk_q    <= 1'b0;
         d1_q      <= 1'b0;
         d2_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         bit_q     <= bit_d;
         fetch_q   <= fetch_d;
         live1_q   <= live1_d;
         live2_q   <= live2_d;
         sr1_q     <= sr1_d;
         sr2_q     <= sr2_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         resetn_q  <= resetn_d;
         sclk_q    <= sclk_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign cfg_rd_en     = rd_en_q;
   assign cfg_rd_addr   = rd_addr_q;
   assign serial_resetn = resetn_q;
   assign serial_clock  = sclk_q;
   assign serial_data_1 = d1_q;
   assign serial_data_2 = d2_q;

endmodule

// File: tb/tb_mprj_io_serial_loader.sv
// Bench for mprj_io_serial_loader: three geometries, scoreboarded chain bits and
// read addresses, serial-clock timing and reset behaviour.
module tb_mprj_io_serial_loader;

   localparam int unsigned CB = 13;
   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start [NI];
   logic busy [NI], done [NI], rd_en [NI], resetn [NI], sclk [NI], d1 [NI], d2 [NI];
   logic [5:0] addr [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned P1 = (g == 0) ? 19 : 3;
      localparam int unsigned P2 = (g == 0) ? 19 : 5;
      localparam int unsigned HP = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      logic [CB-1:0] mem_q;
      // Register-file model: word valid only in the cycle after the strobe.
      always @(posedge clk) mem_q <= rd_en[g] ? (CB'(13'h1000) | CB'(addr[g])) : '1;
      mprj_io_serial_loader #(
         .NUM_PADS_1 (P1),
         .NUM_PADS_2 (P2),
         .CFG_BITS   (CB),
         .HALF_PERIOD(HP)
      ) u_dut (
         .clk          (clk),
         .reset        (rst),
         .start        (start[g]),
         .busy         (busy[g]),
         .done         (done[g]),
         .cfg_rd_en    (rd_en[g]),
         .cfg_rd_addr  (addr[g]),
         .cfg_rd_data  (mem_q),
         .serial_resetn(resetn[g]),
         .serial_clock (sclk[g]),
         .serial_data_1(d1[g]),
         .serial_data_2(d2[g])
      );
   end

   int total = 0;
   int bad = 0;
   int sel = 0;

   // Observation side, recorded for the instance under test.
   bit obs1 [$], obs2 [$];
   logic [5:0] rdlog [$];
   int edges = 0, dones = 0, viol = 0, done_busy = 0;
   int hi_run = 0, hi_min = 1000, hi_max = 0, per_min = 1000, cyc = 0, last_rise = -1;
   logic psclk = 1'b0, pd1 = 1'b0, pd2 = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (start[sel] && !busy[sel] && !rst) begin
         obs1.delete(); obs2.delete(); rdlog.delete();
         edges = 0; dones = 0; viol = 0; done_busy = 0;
         hi_run = 0; hi_min = 1000; hi_max = 0; per_min = 1000; last_rise = -1;
      end
      if (rd_en[sel]) rdlog.push_back(addr[sel]);
      if (done[sel]) begin
         dones++;
         if (busy[sel]) done_busy++;
      end
      if (sclk[sel]) begin
         hi_run++;
         if (d1[sel] !== pd1 || d2[sel] !== pd2) viol++;
         if (!psclk) begin
            edges++;
            obs1.push_back(d1[sel]);
            obs2.push_back(d2[sel]);
            if (last_rise >= 0 && (cyc - last_rise) < per_min) per_min = cyc - last_rise;
            last_rise = cyc;
         end
      end else if (psclk) begin
         if (hi_run < hi_min) hi_min = hi_run;
         if (hi_run > hi_max) hi_max = hi_run;
         hi_run = 0;
      end
      psclk = sclk[sel];
      pd1   = d1[sel];
      pd2   = d2[sel];
   end

   // Expectation side: pushed when an accepted start is driven.
   bit e1 [$], e2 [$];
   logic [5:0] erd [$];

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, o, e);
      end
   endtask

   function automatic logic [31:0] outs(input int i);
      return 32'({busy[i], done[i], rd_en[i], addr[i], resetn[i], sclk[i], d1[i], d2[i]});
   endfunction

   task automatic push_expect(input int p1, input int p2);
      int w;
      logic [CB-1:0] w1, w2;
      w = (p1 > p2) ? p1 : p2;
      e1.delete(); e2.delete(); erd.delete();
      for (int k = 0; k < w; k++) begin
         w1 = '0;
         w2 = '0;
         if (k >= w - p1) begin
            w1 = CB'(32'h1000 | (p1 - 1 - (k - (w - p1))));
            erd.push_back(6'(p1 - 1 - (k - (w - p1))));
         end
         if (k >= w - p2) begin
            w2 = CB'(32'h1000 | (p1 + p2 - 1 - (k - (w - p2))));
            erd.push_back(6'(p1 + p2 - 1 - (k - (w - p2))));
         end
         for (int b = CB - 1; b >= 0; b--) begin
            e1.push_back(w1[b]);
            e2.push_back(w2[b]);
         end
      end
   endtask

   task automatic pulse_start(input int i, input int p1, input int p2, input bit accept);
      @(posedge clk); #1;
      if (accept) push_expect(p1, p2);
      start[i] = 1'b1;
      @(posedge clk); #1;
      start[i] = 1'b0;
      if (accept) chk($sformatf("busy after start i%0d", i), busy[i], 1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (dones == 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " done within budget"}, (dones != 0), 1);
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic check_load(input string tag, input int p1, input int p2);
      int w;
      logic [CB-1:0] ow1, ow2, xw1, xw2;
      w = (p1 > p2) ? p1 : p2;
      chk({tag, " rising edges"}, edges, w * CB);
      chk({tag, " done pulses"}, dones, 1);
      chk({tag, " busy during done"}, done_busy, 0);
      chk({tag, " data moved while clock high"}, viol, 0);
      chk({tag, " busy after load"}, busy[sel], 0);
      chk({tag, " read count"}, rdlog.size(), erd.size());
      for (int j = 0; j < rdlog.size() && erd.size() > 0; j++)
         chk($sformatf("%s read addr %0d", tag, j), rdlog[j], erd.pop_front());
      if (obs1.size() == w * CB) begin
         for (int k = 0; k < w; k++) begin
            for (int b = CB - 1; b >= 0; b--) begin
               ow1[b] = obs1[k * CB + (CB - 1 - b)];
               ow2[b] = obs2[k * CB + (CB - 1 - b)];
               xw1[b] = e1.pop_front();
               xw2[b] = e2.pop_front();
            end
            chk($sformatf("%s chain1 slot %0d", tag, k), ow1, xw1);
            chk($sformatf("%s chain2 slot %0d", tag, k), ow2, xw2);
         end
      end
   endtask

   task automatic check_timing(input string tag, input int hp);
      chk({tag, " clock period"}, per_min, 2 * hp);
      chk({tag, " min high run"}, hi_min, hp);
      chk({tag, " max high run"}, hi_max, hp);
   endtask

   initial begin
      int n;
      logic [CB-1:0] first1, first2;
      for (int i = 0; i < NI; i++) start[i] = 1'b0;

      // Reset state, then serial_resetn rises on the first clock after release.
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) chk($sformatf("outputs in reset i%0d", i), outs(i), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) chk($sformatf("outputs after release i%0d", i), outs(i), 32'h8);

      // Full default load.
      sel = 0;
      pulse_start(0, 19, 19, 1'b1);
      wait_done("default", 3000);
      for (int b = 0; b < CB; b++) begin
         first1[CB - 1 - b] = (obs1.size() > b) ? obs1[b] : 1'bx;
         first2[CB - 1 - b] = (obs2.size() > b) ? obs2[b] : 1'bx;
      end
      chk("default first chain1 word", first1, 13'h1012);
      chk("default first chain2 word", first2, 13'h1025);
      check_load("default", 19, 19);
      check_timing("default", 2);

      // A second start during a load is ignored.
      pulse_start(0, 19, 19, 1'b1);
      repeat (300) @(posedge clk);
      pulse_start(0, 19, 19, 1'b0);
      wait_done("restart ignored", 3000);
      check_load("restart ignored", 19, 19);

      // Reset at slot 5, bit 7: immediate reset values, no done, clean reload.
      pulse_start(0, 19, 19, 1'b1);
      n = 0;
      while (edges < 5 * CB + 7 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reached slot 5 bit 7", edges, 5 * CB + 7);
      rst = 1'b1;
      #1;
      chk("outputs at mid-load reset", outs(0), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("no done after mid-load reset", dones, 0);
      @(posedge clk); #1;
      chk("idle after mid-load reset", outs(0), 32'h8);
      pulse_start(0, 19, 19, 1'b1);
      wait_done("after reset", 3000);
      check_load("after reset", 19, 19);

      // Unequal chains, HALF_PERIOD=1.
      sel = 1;
      pulse_start(1, 3, 5, 1'b1);
      wait_done("3x5 hp1", 1500);
      check_load("3x5 hp1", 3, 5);
      check_timing("3x5 hp1", 1);

      // Unequal chains, HALF_PERIOD=4.
      sel = 2;
      pulse_start(2, 3, 5, 1'b1);
      wait_done("3x5 hp4", 2000);
      check_load("3x5 hp4", 3, 5);
      check_timing("3x5 hp4", 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
